i2s_audio_tx: RTL

I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_audio_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S audio transmitter.
package i2s_pkg;

    // One frame is 64 BCK periods: a 32-slot left word followed by a 32-slot right word.
    localparam int FRAME_SLOTS = 64;
    localparam int SLOT_BITS   = 32;

    // Default channel sample width; the transmitter itself takes its width as a parameter.
    localparam int DEFAULT_SAMPLE_W = 16;

    typedef struct packed {
        logic [DEFAULT_SAMPLE_W-1:0] left;
        logic [DEFAULT_SAMPLE_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: divides clk_sys into BCK, counts 64 slots per frame and
// serializes a double-buffered left/right sample pair MSB-first, one BCK
// after each LRCK change.
//
// Handshake: a pair is taken at a rising clk_sys edge when sample_valid is
// high and either the pending slot is empty (sample_ready = 1), or that edge
// is a frame start that moves the pending pair into the frame register and so
// frees the slot in the same cycle. sample_ready is simply !pend_full, so it
// has no combinational dependence on sample_valid; outside those two cases an
// offered pair is left untouched and must be held by the producer.
module i2s_audio_tx #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                I2S_BCK,
    output logic                I2S_LRCK,
    output logic                I2S_DATA,
    output logic                underrun
);
    import i2s_pkg::*;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] N_LAST   = 6'(FRAME_SLOTS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("i2s_audio_tx: CLK_DIV must be in 2..255");
    end
    if (SAMPLE_W < 1 || SAMPLE_W > SLOT_BITS - 1) begin : g_bad_width
        $error("i2s_audio_tx: SAMPLE_W must leave slot 0 of each word free");
    end

    logic [7:0]          div_cnt;
    logic                bck;
    logic [5:0]          n;
    logic                lrck;
    logic                data;
    logic                und;
    logic                pend_full;
    logic [SAMPLE_W-1:0] pend_l;
    logic [SAMPLE_W-1:0] pend_r;
    logic [SAMPLE_W-1:0] frm_l;
    logic [SAMPLE_W-1:0] frm_r;

    logic                bck_tick;
    logic                bck_fall;
    logic                frame_start;
    logic                load;
    logic                take;
    logic [5:0]          n_next;
    logic [4:0]          k_next;
    logic [SAMPLE_W-1:0] word;
    logic                bit_next;

    // Edge/slot decode and the serial bit that goes out with the next slot.
    always_comb begin
        bck_tick    = (div_cnt == DIV_LAST);
        bck_fall    = bck_tick && bck;
        frame_start = bck_fall && (n == N_LAST);
        load        = frame_start && pend_full;
        take        = sample_valid && (!pend_full || frame_start);
        n_next      = n + 6'd1;
        k_next      = n_next[4:0];
        word        = n_next[5] ? frm_r : frm_l;
        bit_next    = 1'b0;
        // Slot k (1..SAMPLE_W) carries bit SAMPLE_W-k; slot 0 and the tail stay 0.
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (int'(k_next) == SAMPLE_W - i) begin
                bit_next = word[i];
            end
        end
    end

    // Divider: wrap at CLK_DIV-1 and toggle BCK on every wrap.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= 8'd0;
            bck     <= 1'b0;
        end else if (bck_tick) begin
            div_cnt <= 8'd0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Slot counter and serializer advance together on BCK falling edges only.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            n    <= 6'd0;
            lrck <= 1'b0;
            data <= 1'b0;
        end else if (bck_fall) begin
            n    <= n_next;
            lrck <= n_next[5];
            data <= bit_next;
        end
    end

    // Underrun: one-cycle flag when a frame begins with nothing pending.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            und <= 1'b0;
        end else begin
            und <= frame_start && !pend_full;
        end
    end

    // Double buffer: pending slot fed by the producer, frame register fed at frame start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_full <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            frm_l     <= '0;
            frm_r     <= '0;
        end else begin
            if (load) begin
                frm_l <= pend_l;
                frm_r <= pend_r;
            end
            if (take) begin
                pend_l    <= sample_l;
                pend_r    <= sample_r;
                pend_full <= 1'b1;
            end else if (load) begin
                pend_full <= 1'b0;
            end
        end
    end

    assign sample_ready = ~pend_full;
    assign I2S_BCK      = bck;
    assign I2S_LRCK     = lrck;
    assign I2S_DATA     = data;
    assign underrun     = und;

endmodule
